mult_shift_add: RTL and testbench

Parametrised sequential shift-add multiplier: the successor to the fixed 9-bit accumulator of the 4x4 multiplier, now containing the accumulator datapath and its control FSM. It multiplies two N-bit operands, one bit per clock, in unsigned or two's-complement mode chosen per operation. A Start/Busy/Done handshake lets a host sequencer launch an operation and collect the product. It drops in wherever the multiplier top previously wired ACC plus external control.

---
 rtl/mult_shift_add.sv | 95 +++++++++
 tb/tb_mult_shift_add.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mult_shift_add.sv
// Sequential shift-add multiplier, N-bit operands, one bit per clock.
// Unsigned or two's-complement per operation, with a Start/Busy/Done handshake.
module mult_shift_add #(
  parameter int N = 4
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           Start,
  input  logic           Signed,
  input  logic [N-1:0]   Multiplicando,
  input  logic [N-1:0]   Multiplicador,
  output logic [2*N-1:0] Produto,
  output logic           Busy,
  output logic           Done
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [2*N:0]  acc;
  logic [2*N:0]  acc_next;
  logic [N-1:0]  mcand;
  logic          sgn;
  logic [CW-1:0] cnt;
  logic [N:0]    u;
  logic [N:0]    m_ext;
  logic [N:0]    u_next;

  // The MSB of the multiplier carries negative weight in signed mode,
  // so the last partial product is subtracted instead of added.
  always_comb begin
    u      = acc[2*N:N];
    m_ext  = {sgn & mcand[N-1], mcand};
    u_next = u;
    if (acc[0]) begin
      if (sgn && (cnt == LAST)) u_next = u - m_ext;
      else                      u_next = u + m_ext;
    end
    acc_next = {sgn & u_next[N], u_next, acc[N-1:1]};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      sgn     <= 1'b0;
      cnt     <= '0;
      Produto <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            acc   <= {{(N+1){1'b0}}, Multiplicador};
            mcand <= Multiplicando;
            sgn   <= Signed;
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            Produto <= acc_next[2*N-1:0];
            Done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_shift_add.sv
// Directed bench for mult_shift_add at N=4 and N=8 with hand-computed products.
module tb_mult_shift_add;

  logic        Clk;
  logic        Rst;
  logic        start4, signed4, start8, signed8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic [7:0]  prod4;
  logic [15:0] prod8;
  logic        busy4, done4, busy8, done8;

  int compared;
  int mismatched;

  mult_shift_add #(.N(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .Start(start4), .Signed(signed4),
    .Multiplicando(a4), .Multiplicador(b4),
    .Produto(prod4), .Busy(busy4), .Done(done4)
  );

  mult_shift_add #(.N(8)) dut8 (
    .Clk(Clk), .Rst(Rst), .Start(start8), .Signed(signed8),
    .Multiplicando(a8), .Multiplicador(b8),
    .Produto(prod8), .Busy(busy8), .Done(done8)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Launches one operation and follows it to IDLE. With hammer set, Start is
  // held high with other operands through RUN and DONE and must be ignored.
  task automatic op(input string tag, input bit w8, input bit sg,
                    input logic [7:0] a, input logic [7:0] b,
                    input logic [15:0] exp, input bit hammer);
    int n;
    int dones;
    int done_at;
    logic cur_done, cur_busy;
    logic [15:0] cur_prod;
    n = w8 ? 8 : 4;
    dones = 0;
    done_at = -1;
    if (w8) begin start8 = 1'b1; signed8 = sg; a8 = a; b8 = b; end
    else    begin start4 = 1'b1; signed4 = sg; a4 = a[3:0]; b4 = b[3:0]; end
    for (int k = 0; k <= n + 1; k++) begin
      tick();
      if (k == 0 && !hammer) begin start4 = 1'b0; start8 = 1'b0; end
      if (hammer && k < n + 1) begin
        if (w8) begin start8 = 1'b1; signed8 = ~sg; a8 = ~a; b8 = b ^ 8'h5A; end
        else    begin start4 = 1'b1; signed4 = ~sg; a4 = ~a[3:0]; b4 = b[3:0] ^ 4'h6; end
      end
      if (hammer && k == n + 1) begin start4 = 1'b0; start8 = 1'b0; end
      cur_done = w8 ? done8 : done4;
      cur_busy = w8 ? busy8 : busy4;
      cur_prod = w8 ? prod8 : {8'h00, prod4};
      if (cur_done) begin dones++; done_at = k; end
      if (k == 0) check({tag, "/busy_run"}, {31'd0, cur_busy}, 32'd1);
      if (k == n) check({tag, "/prod"}, {16'd0, cur_prod}, {16'd0, exp});
      if (k == n + 1) check({tag, "/busy_idle"}, {31'd0, cur_busy}, 32'd0);
    end
    check({tag, "/done_at"}, done_at, n);
    check({tag, "/done_cnt"}, dones, 1);
    if (hammer) begin
      tick();
      cur_busy = w8 ? busy8 : busy4;
      cur_prod = w8 ? prod8 : {8'h00, prod4};
      check({tag, "/no_restart"}, {31'd0, cur_busy}, 32'd0);
      check({tag, "/prod_hold"}, {16'd0, cur_prod}, {16'd0, exp});
    end
  endtask

  initial begin
    int dones;
    compared = 0;
    mismatched = 0;
    Rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start4 = 1'($urandom); signed4 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom);
      start8 = 1'($urandom); signed8 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom);
      tick();
    end
    check("rst/prod", {24'd0, prod4}, 32'd0);
    check("rst/busy", {31'd0, busy4}, 32'd0);
    check("rst/done", {31'd0, done4}, 32'd0);
    check("rst/prod8", {16'd0, prod8}, 32'd0);
    Rst = 1'b0;
    start4 = 1'b0; start8 = 1'b0;
    repeat (3) tick();
    check("idle/prod", {24'd0, prod4}, 32'd0);
    check("idle/busy", {31'd0, busy4}, 32'd0);
    check("idle/done", {31'd0, done4}, 32'd0);

    op("u15x15", 1'b0, 1'b0, 8'hF, 8'hF, 16'h00E1, 1'b0);
    op("u13x11", 1'b0, 1'b0, 8'hD, 8'hB, 16'h008F, 1'b0);
    op("u0x9",   1'b0, 1'b0, 8'h0, 8'h9, 16'h0000, 1'b0);
    op("u9x0",   1'b0, 1'b0, 8'h9, 8'h0, 16'h0000, 1'b0);
    op("s-8x-8", 1'b0, 1'b1, 8'h8, 8'h8, 16'h0040, 1'b0);
    op("s7x-8",  1'b0, 1'b1, 8'h7, 8'h8, 16'h00C8, 1'b0);
    op("s-1x5",  1'b0, 1'b1, 8'hF, 8'h5, 16'h00FB, 1'b0);
    op("uFx5",   1'b0, 1'b0, 8'hF, 8'h5, 16'h004B, 1'b0);
    op("hammer", 1'b0, 1'b0, 8'h6, 8'h7, 16'h002A, 1'b1);

    // Abort: Rst sampled at the edge that ends the 2nd RUN cycle.
    start4 = 1'b1; signed4 = 1'b0; a4 = 4'hF; b4 = 4'hF;
    tick();
    start4 = 1'b0;
    tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("abort/busy", {31'd0, busy4}, 32'd0);
    check("abort/prod", {24'd0, prod4}, 32'd0);
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done4) dones++;
    end
    check("abort/no_done", dones, 0);
    op("u3x3", 1'b0, 1'b0, 8'h3, 8'h3, 16'h0009, 1'b0);

    op("n8u255x255",  1'b1, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0);
    op("n8s-128x127", 1'b1, 1'b1, 8'h80, 8'h7F, 16'hC080, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
